knowles_sub32_pipe: RTL



---
 rtl/knowles_sub32_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/knowles_sub32_pipe.sv
// Pipelined 32-bit subtractor on a radix-2 Knowles prefix network with
// elastic valid/ready stages after the prefix levels selected by REG_MASK.
module knowles_sub32_pipe #(
    parameter int         KNOWLES_S2 = 2,
    parameter int         KNOWLES_S3 = 4,
    parameter int         KNOWLES_S4 = 8,
    parameter int         KNOWLES_S5 = 16,
    parameter logic [5:0] REG_MASK   = 6'b101010
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        In_valid,
    output logic        In_ready,
    input  logic [32:1] A,
    input  logic [32:1] B,
    input  logic        Bi,
    output logic        Out_valid,
    input  logic        Out_ready,
    output logic [32:1] D,
    output logic        Bo,
    output logic        Z,
    output logic        N,
    output logic        V
);

    // Handshake: a transfer happens on an edge where valid & ready are both 1;
    // valid never depends on ready, and data is held while valid & ~ready.

    // Index 0 of g/p is the borrow-in slot; pb keeps the bitwise propagate.
    typedef struct packed {
        logic [32:0] g;
        logic [32:0] p;
        logic [32:1] pb;
        logic        a_s;
        logic        b_s;
    } stg_t;

    stg_t       s_out [0:5];
    stg_t       s_reg [0:5];
    logic [5:0] v_out;
    logic [5:0] vld_r;
    logic [5:0] ld;

    function automatic int fanout(input int k);
        case (k)
            2:       return KNOWLES_S2;
            3:       return KNOWLES_S3;
            4:       return KNOWLES_S4;
            5:       return KNOWLES_S5;
            default: return 1;
        endcase
    endfunction

    // Odd levels take true-polarity inputs and emit inverted (AOI), even
    // levels take inverted inputs and emit true (OAI). Node 32 never merges:
    // it is folded into the carry-out at the end.
    function automatic stg_t prefix_stage(input stg_t x, input int k);
        stg_t y;
        int   d;
        int   f;
        int   j;
        y = x;
        d = 1 << (k - 1);
        f = fanout(k);
        for (int i = 0; i <= 32; i++) begin
            j = (i | (f - 1)) - d;
            if (i <= 31 && j >= 0) begin
                if (k % 2 == 1) begin
                    y.g[6'(i)] = ~(x.g[6'(i)] | (x.p[6'(i)] & x.g[6'(j)]));
                    y.p[6'(i)] = ~(x.p[6'(i)] & x.p[6'(j)]);
                end else begin
                    y.g[6'(i)] = ~(x.g[6'(i)] & (x.p[6'(i)] | x.g[6'(j)]));
                    y.p[6'(i)] = ~(x.p[6'(i)] | x.p[6'(j)]);
                end
            end else begin
                y.g[6'(i)] = ~x.g[6'(i)];
                y.p[6'(i)] = ~x.p[6'(i)];
            end
        end
        return y;
    endfunction

    always_comb begin : datapath
        stg_t cur;
        logic cur_v;
        cur.g   = {A & ~B, ~Bi};
        cur.p   = {A ^ ~B, 1'b0};
        cur.pb  = A ^ ~B;
        cur.a_s = A[32];
        cur.b_s = B[32];
        cur_v   = In_valid;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) cur = prefix_stage(cur, k);
            s_out[3'(k)] = cur;
            v_out[3'(k)] = cur_v;
            if (REG_MASK[3'(k)]) begin
                cur   = s_reg[3'(k)];
                cur_v = vld_r[3'(k)];
            end
        end
    end

    // Load enables ripple back from the output; an empty stage always loads.
    always_comb begin : stall_chain
        logic dn;
        dn = Out_ready;
        for (int k = 5; k >= 0; k--) begin
            if (REG_MASK[3'(k)]) begin
                ld[3'(k)] = ~vld_r[3'(k)] | dn;
                dn        = ld[3'(k)];
            end else begin
                ld[3'(k)] = dn;
            end
        end
        In_ready = dn;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_r <= '0;
            for (int k = 0; k <= 5; k++) s_reg[3'(k)] <= '0;
        end else begin
            for (int k = 0; k <= 5; k++) begin
                if (REG_MASK[3'(k)] && ld[3'(k)]) begin
                    vld_r[3'(k)] <= v_out[3'(k)];
                    s_reg[3'(k)] <= s_out[3'(k)];
                end
            end
        end
    end

    // Level 5 leaves g/p inverted; carry[i] is the true G[i:0].
    always_comb begin : result
        logic [32:0] carry;
        logic [32:1] d_c;
        logic        co;
        logic        vo;
        vo    = vld_r[5];
        carry = ~s_reg[5].g;
        d_c   = s_reg[5].pb ^ carry[31:0];
        co    = carry[32] | (~s_reg[5].p[32] & carry[31]);
        Out_valid = vo;
        D  = vo ? d_c : '0;
        Bo = vo & ~co;
        Z  = vo & (d_c == '0);
        N  = vo & d_c[32];
        V  = vo & (s_reg[5].a_s ^ s_reg[5].b_s) & (d_c[32] ^ s_reg[5].a_s);
    end

endmodule
